// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch unit: the FSM state encoding,
// the next-PC select encoding, the halt opcode and a wrapping PC increment.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SRC_INC = 2'b00,
    PC_SRC_RA  = 2'b01,
    PC_SRC_ALU = 2'b10,
    PC_SRC_REG = 2'b11
  } pc_src_t;

  localparam logic [3:0] OPC_HALT = 4'h0;

  // 8-bit increment; 8'hFF rolls over to 8'h00 by plain truncation.
  function automatic logic [7:0] pc_inc(input logic [7:0] pc_val);
    return pc_val + 8'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: fetches one instruction byte per FETCH phase,
// presents it for one EXEC cycle, then selects the next PC and optionally
// records a return address. Opcode 0 halts the unit until reset.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req, imem_addr     instruction read request / address (= pc)
//   imem_ack, imem_data     read-data valid / instruction byte
//   pc_enable, ra_enable    PC update and return-address write (EXEC only)
//   pc_src                  next-PC select: inc, ra, alu_result, reg_target
//   alu_result, reg_target  branch and call targets
//   opcode, operand         ir[7:4], ir[3:0]
//   instr_valid             opcode/operand qualify, one cycle per instruction
//   pc, ra                  current PC and return-address register
//   halted                  core stopped
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  input  logic       pc_enable,
  input  logic       ra_enable,
  input  logic [1:0] pc_src,
  input  logic [7:0] alu_result,
  input  logic [7:0] reg_target,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  output logic       instr_valid,
  output logic [7:0] pc,
  output logic [7:0] ra,
  output logic       halted
);

  fetch_state_t state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   ra_q, ra_d;
  logic [7:0]   ir_q, ir_d;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic         halted_q;
  logic [7:0]   next_pc_s;

  // Next-PC candidate selected by pc_src; ra here is the pre-update value.
  always_comb begin
    next_pc_s = pc_inc(pc_q);
    case (pc_src_t'(pc_src))
      PC_SRC_INC: next_pc_s = pc_inc(pc_q);
      PC_SRC_RA:  next_pc_s = ra_q;
      PC_SRC_ALU: next_pc_s = alu_result;
      PC_SRC_REG: next_pc_s = reg_target;
      default:    next_pc_s = pc_inc(pc_q);
    endcase
  end

  // FSM next state and next values of pc, ra and ir.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ra_d    = ra_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (ir_q[7:4] == OPC_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
          if (pc_enable) begin
            pc_d = next_pc_s;
          end else begin
            pc_d = pc_q;
          end
        end
        if (ra_enable) begin
          ra_d = pc_inc(pc_q);
        end else begin
          ra_d = ra_q;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; the status outputs are registered from the next state
  // so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      ra_q          <= 8'h00;
      ir_q          <= 8'h00;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ra_q          <= ra_d;
      ir_q          <= ir_d;
      imem_req_q    <= (state_d == ST_FETCH);
      instr_valid_q <= (state_d == ST_EXEC);
      halted_q      <= (state_d == ST_HALT);
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign opcode      = ir_q[7:4];
  assign operand     = ir_q[3:0];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign ra          = ra_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       pc_enable;
  logic       ra_enable;
  logic [1:0] pc_src;
  logic [7:0] alu_result;
  logic [7:0] reg_target;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       instr_valid;
  logic [7:0] pc;
  logic [7:0] ra;
  logic       halted;

  int pass_cnt = 0;
  int total_cnt = 0;

  instruction_fetch #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .pc_enable(pc_enable), .ra_enable(ra_enable), .pc_src(pc_src),
    .alu_result(alu_result), .reg_target(reg_target),
    .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
    .pc(pc), .ra(ra), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         lat;
    logic       pe;
    logic       re;
    logic [1:0] src;
    logic [7:0] alu;
    logic [7:0] rt;
    logic [7:0] exp_pc;
    logic [7:0] exp_ra;
    logic       exp_halt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control inputs parked at non-neutral values: must be ignored outside EXEC.
  task automatic junk_ctrl();
    pc_enable  = 1'b1;
    ra_enable  = 1'b1;
    pc_src     = 2'b10;
    alu_result = 8'hAA;
    reg_target = 8'hBB;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("imem_req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input logic [7:0] exp_addr);
    wait_req();
    chk("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_addr});
    imem_ack = 1'b0;
    for (int i = 0; i < v.lat; i++) begin
      step();
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_stable", {24'd0, imem_addr}, {24'd0, exp_addr});
      chk("no_early_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack  = 1'b1;
    imem_data = v.data;
    step();
    imem_ack   = 1'b0;
    imem_data  = 8'h00;
    pc_enable  = v.pe;
    ra_enable  = v.re;
    pc_src     = v.src;
    alu_result = v.alu;
    reg_target = v.rt;
    chk("exec_valid", {31'd0, instr_valid}, 32'd1);
    chk("exec_req", {31'd0, imem_req}, 32'd0);
    chk("exec_opcode", {28'd0, opcode}, {28'd0, v.data[7:4]});
    chk("exec_operand", {28'd0, operand}, {28'd0, v.data[3:0]});
    step();
    junk_ctrl();
    chk("valid_one_cycle", {31'd0, instr_valid}, 32'd0);
    chk("pc_after", {24'd0, pc}, {24'd0, v.exp_pc});
    chk("ra_after", {24'd0, ra}, {24'd0, v.exp_ra});
    chk("halted_after", {31'd0, halted}, {31'd0, v.exp_halt});
  endtask

  initial begin
    logic [7:0] exp_addr;

    //          data   lat pe    re    src    alu    rt     pc     ra     halt
    vecs[0] = '{8'h61, 0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0};
    vecs[1] = '{8'h23, 5, 1'b1, 1'b0, 2'b10, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[2] = '{8'h34, 0, 1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{8'h45, 1, 1'b1, 1'b0, 2'b10, 8'h10, 8'h00, 8'h10, 8'h00, 1'b0};
    vecs[4] = '{8'h5A, 0, 1'b1, 1'b1, 2'b11, 8'h00, 8'h40, 8'h40, 8'h11, 1'b0};
    vecs[5] = '{8'h7B, 2, 1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 8'h11, 8'h11, 1'b0};
    vecs[6] = '{8'h8C, 0, 1'b1, 1'b1, 2'b10, 8'hF0, 8'h00, 8'hF0, 8'h12, 1'b0};
    vecs[7] = '{8'h9D, 0, 1'b0, 1'b0, 2'b10, 8'h33, 8'h00, 8'hF0, 8'h12, 1'b0};
    vecs[8] = '{8'hAE, 3, 1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 8'h12, 8'hF1, 1'b0};
    vecs[9] = '{8'h07, 0, 1'b1, 1'b0, 2'b10, 8'h55, 8'h00, 8'h12, 8'hF1, 1'b1};

    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_data = 8'h00;
    junk_ctrl();
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_ra", {24'd0, ra}, 32'd0);
    chk("rst_ir", {24'd0, opcode, operand}, 32'd0);

    rst_n = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("req_rises", {31'd0, imem_req}, 32'd1);

    exp_addr = 8'h00;
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], exp_addr);
      exp_addr = vecs[i].exp_pc;
    end

    // Halted: outputs frozen, acks ignored.
    for (int i = 0; i < 4; i++) begin
      imem_ack  = 1'b1;
      imem_data = 8'hFF;
      step();
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", {24'd0, pc}, 32'h12);
      chk("halt_ra", {24'd0, ra}, 32'hF1);
      chk("halt_ir", {24'd0, opcode, operand}, 32'h07);
    end
    imem_ack = 1'b0;

    rst_n = 1'b0;
    #1;
    chk("halt_rst_pc", {24'd0, pc}, 32'd0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    step();
    rst_n = 1'b1;

    // Reset during a pending fetch, ack arriving while in reset.
    wait_req();
    step();
    step();
    chk("pend_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_req", {31'd0, imem_req}, 32'd0);
    imem_ack  = 1'b1;
    imem_data = 8'hE5;
    step();
    step();
    chk("ack_in_rst_ir", {24'd0, opcode, operand}, 32'd0);
    chk("ack_in_rst_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    step();
    chk("restart_ir", {24'd0, opcode, operand}, 32'd0);
    run_vec(vecs[0], 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction read request.
REQ-006 SHALL have port imem_addr  output  8  instruction address (equals pc).
REQ-007 SHALL have port imem_ack  input  1  read data valid.
REQ-008 SHALL have port imem_data  input  8  instruction byte.
REQ-009 SHALL have port pc_enable  input  1  PC update permitted (from control unit).
REQ-010 SHALL have port ra_enable  input  1  return-address write (from control unit).
REQ-011 SHALL have port pc_src  input  2  next-PC select: 00 pc+1, 01 ra, 10 alu_result, 11 reg_target.
REQ-012 SHALL have port alu_result  input  8  branch target.
REQ-013 SHALL have port reg_target  input  8  call target.
REQ-014 SHALL have port opcode  output  4  ir[7:4], to control unit.
REQ-015 SHALL have port operand  output  4  ir[3:0].
REQ-016 SHALL have port instr_valid  output  1  opcode/operand valid, execute cycle.
REQ-017 SHALL have port pc  output  8  current PC.
REQ-018 SHALL have port ra  output  8  return-address register.
REQ-019 SHALL have port halted  output  1  core stopped.

Function
REQ-020 SHALL implement FSM IDLE, FETCH, EXEC, HALT; IDLE->FETCH unconditionally after one cycle.
REQ-021 FETCH: imem_req=1, imem_addr=pc held stable; on imem_ack=1 SHALL capture imem_data into ir and go to EXEC; else remain in FETCH indefinitely.
REQ-022 imem_ack in the first FETCH cycle SHALL be accepted (minimum fetch latency 1 cycle).
REQ-023 imem_ack outside FETCH SHALL be ignored; ir unchanged.
REQ-024 EXEC: instr_valid=1 for exactly one cycle, imem_req=0; next state FETCH, or HALT if ir[7:4]==4'b0000.
REQ-025 On EXEC exit with pc_enable=1 and opcode!=0: pc <= mux(pc_src); pc+1 wraps 8'hFF->8'h00.
REQ-026 On EXEC exit with pc_enable=0: pc SHALL hold (same address re-fetched).
REQ-027 On EXEC exit with ra_enable=1: ra <= pc+1 (wrapping), independent of pc_enable.
REQ-028 ra_enable=1 with pc_src=01 in same cycle: pc SHALL take the old ra value.
REQ-029 pc_enable/ra_enable/pc_src SHALL be ignored outside EXEC.
REQ-030 HALT: halted=1, imem_req=0, instr_valid=0, pc/ra frozen; exit only via reset.
REQ-031 opcode/operand SHALL always reflect ir; qualified by instr_valid only.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, pc=RESET_PC, ra=0, ir=0.
REQ-033 During and after reset all of imem_req, instr_valid, halted SHALL be 0 until IDLE is left.
REQ-034 Reset asserted mid-FETCH SHALL drop imem_req immediately; a pending ack SHALL be discarded.

Structure
REQ-035 State enum fetch_state_t, pc_src_t encodings and constant OPC_HALT=4'h0 SHALL live in shared package cpu_pkg.
REQ-036 No sub-module; next-PC mux SHALL be inline combinational logic.

Verification
REQ-037 Reset release, imem_ack tied 1, memory[0]=8'h61 -> imem_req rises 1 cycle after release, instr_valid pulse with opcode=6, pc=8'h01 after.
REQ-038 Ack delayed 5 cycles -> imem_req held, imem_addr stable 5 cycles, single instr_valid pulse.
REQ-039 pc=8'hFF, pc_src=00, pc_enable=1 -> pc=8'h00.
REQ-040 pc=8'h10, ra_enable=1, pc_src=11, reg_target=8'h40 -> ra=8'h11, pc=8'h40; then pc_src=01 -> pc=8'h11.
REQ-041 Fetch 8'h00 -> halted=1, imem_req=0 permanently, pc unchanged; rst_n low -> pc=RESET_PC, halted=0.
REQ-042 Reset asserted during wait for ack, ack arrives during reset -> ack ignored, ir=0, fetch restarts at RESET_PC.
